// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init FSM states and default
// timing constants. The refresh and read/write stages reuse this package.
package sdram_pkg;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

  // Init FSM states
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_WAIT = 3'd0;
  localparam state_t S_PRE  = 3'd1;
  localparam state_t S_TRP  = 3'd2;
  localparam state_t S_REF  = 3'd3;
  localparam state_t S_TRFC = 3'd4;
  localparam state_t S_MRS  = 3'd5;
  localparam state_t S_TMRD = 3'd6;
  localparam state_t S_DONE = 3'd7;

  // Default timing constants
  localparam int          DEF_CLK_FREQ_MHZ = 100;
  localparam int          DEF_T_POWERUP_US = 200;
  localparam int          DEF_T_RP         = 2;
  localparam int          DEF_T_RFC        = 7;
  localparam int          DEF_T_MRD        = 2;
  localparam int          DEF_REF_NUM      = 8;
  localparam logic [12:0] DEF_MODE_REG     = 13'h032;

  // Address bit that selects "all banks" on PRECHARGE
  localparam int A_ALL_BANKS_BIT = 10;

  // Largest of three values, used to size shared delay counters
  function automatic int max3(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sdram_delay_cnt.sv
// Loadable down-counter. done_o is high during the last cycle of the loaded
// interval, so a value of N spaces the next command N cycles after the load.
module sdram_delay_cnt #(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load has priority; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/sdram_init.sv
// SDRAM power-up initialisation: power-up wait, PRECHARGE ALL, REF_NUM
// AUTO REFRESH commands, LOAD MODE, then INIT_DONE. All outputs are
// registered from the next FSM state so each output reflects the state the
// FSM occupies in that cycle.
module sdram_init
  import sdram_pkg::*;
#(
  parameter int          CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ,
  parameter int          T_POWERUP_US = DEF_T_POWERUP_US,
  parameter int          T_RP         = DEF_T_RP,
  parameter int          T_RFC        = DEF_T_RFC,
  parameter int          T_MRD        = DEF_T_MRD,
  parameter int          REF_NUM      = DEF_REF_NUM,
  parameter logic [12:0] MODE_REG     = DEF_MODE_REG
) (
  input  logic        REF_CLK,
  input  logic        RST_N,
  output logic        CKE,
  output logic        CS_N,
  output logic        RAS_N,
  output logic        CAS_N,
  output logic        WE_N,
  output logic [12:0] A,
  output logic [1:0]  BS,
  output logic        INIT_DONE
);

  localparam int W      = CLK_FREQ_MHZ * T_POWERUP_US;
  localparam int WAIT_W = $clog2(W + 1);
  localparam int REF_W  = $clog2(REF_NUM + 1);
  localparam int DLY_W  = $clog2(max3(T_RP, T_RFC, T_MRD) + 1);

  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(W);
  localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REF_NUM);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;

  logic              dly_load;
  logic [DLY_W-1:0]  dly_val;
  logic              dly_done;
  logic              ref_more;

  logic              cke_q;
  logic [3:0]        cmd_q, cmd_d;
  logic [12:0]       addr_q, addr_d;
  logic [1:0]        bs_q;
  logic              done_q, done_d;

  // Shared spacing timer for tRP, tRFC and tMRD
  sdram_delay_cnt #(
    .WIDTH (DLY_W)
  ) u_delay (
    .clk_i      (REF_CLK),
    .rst_ni     (RST_N),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .done_o     (dly_done)
  );

  assign ref_more = (ref_cnt_q < REF_LAST);

  // Next-state logic. Command states consult the timer directly so a
  // spacing of one cycle goes command-to-command with no wait state between.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: if (wait_cnt_q == WAIT_END) state_d = S_PRE;
      S_PRE:  state_d = dly_done ? S_REF : S_TRP;
      S_TRP:  if (dly_done) state_d = S_REF;
      S_REF: begin
        if (!dly_done)     state_d = S_TRFC;
        else if (ref_more) state_d = S_REF;
        else               state_d = S_MRS;
      end
      S_TRFC: if (dly_done) state_d = ref_more ? S_REF : S_MRS;
      S_MRS:  state_d = dly_done ? S_DONE : S_TMRD;
      S_TMRD: if (dly_done) state_d = S_DONE;
      S_DONE: state_d = S_DONE;
      default: state_d = S_WAIT;
    endcase
  end

  // Power-up wait and refresh counters, both saturating
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    if (state_q == S_WAIT && wait_cnt_q != WAIT_END) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    if (state_d == S_REF && ref_more) begin
      ref_cnt_d = ref_cnt_q + REF_W'(1);
    end
  end

  // Reload the spacing timer whenever a command is about to be issued
  always_comb begin
    dly_load = 1'b0;
    dly_val  = '0;
    case (state_d)
      S_PRE: begin dly_load = 1'b1; dly_val = DLY_W'(T_RP);  end
      S_REF: begin dly_load = 1'b1; dly_val = DLY_W'(T_RFC); end
      S_MRS: begin dly_load = 1'b1; dly_val = DLY_W'(T_MRD); end
      default: ;
    endcase
  end

  // Decode bus command and address for the state being entered
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    done_d = (state_d == S_DONE);
    case (state_d)
      S_PRE: begin
        cmd_d                   = CMD_PRECHARGE;
        addr_d[A_ALL_BANKS_BIT] = 1'b1;
      end
      S_REF: cmd_d = CMD_AUTO_REFRESH;
      S_MRS: begin
        cmd_d  = CMD_LOAD_MODE;
        addr_d = MODE_REG;
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge REF_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_WAIT;
      wait_cnt_q <= '0;
      ref_cnt_q  <= '0;
      cke_q      <= 1'b0;
      cmd_q      <= CMD_NOP;
      addr_q     <= '0;
      bs_q       <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      cke_q      <= 1'b1;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      bs_q       <= 2'b00;
      done_q     <= done_d;
    end
  end

  assign CKE       = cke_q;
  assign CS_N      = cmd_q[3];
  assign RAS_N     = cmd_q[2];
  assign CAS_N     = cmd_q[1];
  assign WE_N      = cmd_q[0];
  assign A         = addr_q;
  assign BS        = bs_q;
  assign INIT_DONE = done_q;

endmodule

// File: tb/tb_sdram_init.sv
// Bench for sdram_init: three instances with different timing sets, each
// walked cycle by cycle against an arithmetic model of the init timeline.
module tb_sdram_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n, rst_c_n;

  logic        cke_a, cs_a, ras_a, cas_a, we_a, done_a;
  logic [12:0] a_a;
  logic [1:0]  bs_a;
  logic        cke_b, cs_b, ras_b, cas_b, we_b, done_b;
  logic [12:0] a_b;
  logic [1:0]  bs_b;
  logic        cke_c, cs_c, ras_c, cas_c, we_c, done_c;
  logic [12:0] a_c;
  logic [1:0]  bs_c;

  logic [20:0] vec_a, vec_b, vec_c;
  assign vec_a = {cke_a, cs_a, ras_a, cas_a, we_a, a_a, bs_a, done_a};
  assign vec_b = {cke_b, cs_b, ras_b, cas_b, we_b, a_b, bs_b, done_b};
  assign vec_c = {cke_c, cs_c, ras_c, cas_c, we_c, a_c, bs_c, done_c};

  // W=100 timeline
  sdram_init #(
    .CLK_FREQ_MHZ(100), .T_POWERUP_US(1), .T_RP(2), .T_RFC(7),
    .T_MRD(2), .REF_NUM(8), .MODE_REG(13'h032)
  ) dut_a (
    .REF_CLK(clk), .RST_N(rst_a_n), .CKE(cke_a), .CS_N(cs_a), .RAS_N(ras_a),
    .CAS_N(cas_a), .WE_N(we_a), .A(a_a), .BS(bs_a), .INIT_DONE(done_a)
  );

  // Default parameters (W=20000)
  sdram_init dut_b (
    .REF_CLK(clk), .RST_N(rst_b_n), .CKE(cke_b), .CS_N(cs_b), .RAS_N(ras_b),
    .CAS_N(cas_b), .WE_N(we_b), .A(a_b), .BS(bs_b), .INIT_DONE(done_b)
  );

  // Minimum spacings, W=10
  sdram_init #(
    .CLK_FREQ_MHZ(10), .T_POWERUP_US(1), .T_RP(1), .T_RFC(1),
    .T_MRD(1), .REF_NUM(2), .MODE_REG(13'h032)
  ) dut_c (
    .REF_CLK(clk), .RST_N(rst_c_n), .CKE(cke_c), .CS_N(cs_c), .RAS_N(ras_c),
    .CAS_N(cas_c), .WE_N(we_c), .A(a_c), .BS(bs_c), .INIT_DONE(done_c)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [20:0] RST_VEC = {1'b0, 4'b0111, 13'h0, 2'b00, 1'b0};

  // Expected {CKE, cmd, A, BS, INIT_DONE} at cycle n, from the timeline rules
  function automatic logic [20:0] model(int n, int w, int trp, int trfc,
                                        int nref, int tmrd, logic [12:0] mode);
    logic [3:0]  cmd;
    logic [12:0] addr;
    int          m;
    cmd  = 4'b0111;
    addr = 13'h0;
    m    = w + trp + nref * trfc;
    if (n == w) begin
      cmd  = 4'b0010;
      addr = 13'h0400;
    end else if (n >= w + trp && n < m && ((n - w - trp) % trfc) == 0) begin
      cmd = 4'b0001;
    end else if (n == m) begin
      cmd  = 4'b0000;
      addr = mode;
    end
    return {1'b1, cmd, addr, 2'b00, (n >= m + tmrd)};
  endfunction

  task automatic test_reset();
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    rst_c_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (vec_a !== RST_VEC) begin
      bad++;
      $display("FAIL reset_a got=%h expected=%h", vec_a, RST_VEC);
    end
    total++;
    if (vec_b !== RST_VEC) begin
      bad++;
      $display("FAIL reset_b got=%h expected=%h", vec_b, RST_VEC);
    end
    total++;
    if (vec_c !== RST_VEC) begin
      bad++;
      $display("FAIL reset_c got=%h expected=%h", vec_c, RST_VEC);
    end
    $display("test_reset: reset state checked on all instances");
  endtask

  task automatic test_timeline_a();
    logic [20:0] exp;
    @(negedge clk);
    rst_a_n = 1'b1;
    for (int k = 0; k < 170; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = model(k, 100, 2, 7, 8, 2, 13'h032);
      total++;
      if (vec_a !== exp) begin
        bad++;
        $display("FAIL timeline_a cycle=%0d got=%h expected=%h", k, vec_a, exp);
        break;
      end
    end
    $display("test_timeline_a: cycles 0..169 walked");
  endtask

  task automatic test_after_done();
    logic [20:0] exp;
    exp = model(100000, 100, 2, 7, 8, 2, 13'h032);
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (vec_a !== exp || $isunknown(vec_a)) begin
        bad++;
        $display("FAIL after_done step=%0d got=%h expected=%h", k, vec_a, exp);
        break;
      end
    end
    $display("test_after_done: 1000 idle cycles walked");
  endtask

  task automatic test_reset_mid();
    logic [20:0] exp;
    // fresh sequence, then reset asserted at cycle 130 between clock edges
    @(negedge clk);
    rst_a_n = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    for (int k = 0; k <= 130; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    exp = model(130, 100, 2, 7, 8, 2, 13'h032);
    total++;
    if (vec_a !== exp) begin
      bad++;
      $display("FAIL pre_reset_130 got=%h expected=%h", vec_a, exp);
    end
    #2 rst_a_n = 1'b0;
    #1;
    total++;
    if (vec_a !== RST_VEC) begin
      bad++;
      $display("FAIL async_reset_130 got=%h expected=%h", vec_a, RST_VEC);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (vec_a !== RST_VEC) begin
      bad++;
      $display("FAIL held_reset got=%h expected=%h", vec_a, RST_VEC);
    end
    rst_a_n = 1'b1;
    for (int k = 0; k < 170; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = model(k, 100, 2, 7, 8, 2, 13'h032);
      total++;
      if (vec_a !== exp) begin
        bad++;
        $display("FAIL restart_a cycle=%0d got=%h expected=%h", k, vec_a, exp);
        break;
      end
    end
    $display("test_reset_mid: reset at cycle 130 and restart checked");
  endtask

  task automatic test_random_resets();
    logic [20:0] exp;
    int          r;
    int          hold;
    for (int it = 0; it < 5; it++) begin
      r    = int'($urandom_range(1, 200));
      hold = int'($urandom_range(1, 6));
      @(negedge clk);
      #1 rst_a_n = 1'b0;
      #1;
      total++;
      if (vec_a !== RST_VEC) begin
        bad++;
        $display("FAIL rand_reset it=%0d got=%h expected=%h", it, vec_a, RST_VEC);
      end
      repeat (hold) @(posedge clk);
      @(negedge clk);
      rst_a_n = 1'b1;
      for (int k = 0; k < r; k++) begin
        @(posedge clk);
        @(negedge clk);
        exp = model(k, 100, 2, 7, 8, 2, 13'h032);
        total++;
        if (vec_a !== exp) begin
          bad++;
          $display("FAIL rand_walk it=%0d cycle=%0d got=%h expected=%h", it, k, vec_a, exp);
          break;
        end
      end
      $display("test_random_resets: iter %0d hold=%0d ran %0d cycles", it, hold, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] exp;
    @(negedge clk);
    rst_c_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = model(k, 10, 1, 1, 2, 1, 13'h032);
      total++;
      if (vec_c !== exp) begin
        bad++;
        $display("FAIL back_to_back cycle=%0d got=%h expected=%h", k, vec_c, exp);
        break;
      end
    end
    $display("test_back_to_back: minimum spacing timeline walked");
  endtask

  task automatic test_default();
    logic [20:0] exp;
    @(negedge clk);
    rst_b_n = 1'b1;
    for (int k = 0; k < 20080; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = model(k, 20000, 2, 7, 8, 2, 13'h032);
      total++;
      if (vec_b !== exp) begin
        bad++;
        $display("FAIL default cycle=%0d got=%h expected=%h", k, vec_b, exp);
        break;
      end
    end
    $display("test_default: default timeline walked to cycle 20079");
  endtask

  initial begin
    test_reset();
    test_timeline_a();
    test_after_done();
    test_reset_mid();
    test_random_resets();
    test_back_to_back();
    test_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
